// File: rtl/add_accumulator_8bit_if.sv
// Stream bundle for add_accumulator_8bit: operand input stream and frame-result output stream.
interface add_accumulator_8bit_if #(
  parameter int COUNT_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_sum;
  logic               out_cout;
  logic [COUNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_count
  );
endinterface

// File: rtl/add_accumulator_8bit.sv
// Frame accumulator wrapped around an 8-bit ripple-carry adder; one result per frame.
// Optional build macro ADD_ACC_SATURATE_EN clamps the accumulator at 0xFF on carry-out.

module ripple_adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);
  logic [8:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[8];
endmodule

// state   | meaning
// ST_ACC  | accepting words, summing into acc
// ST_DONE | frame result presented, waiting for out_ready
module add_accumulator_8bit #(
  parameter int COUNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  add_accumulator_8bit_if.slave bus
);
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [7:0]         acc_q, acc_d;
  logic               cflag_q, cflag_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic [7:0] add_sum;
  logic       add_cout;
  logic       accept;

  ripple_adder_8bit u_adder (
    .A    (bus.in_data),
    .B    (acc_q),
    .Cin  (1'b0),
    .Sum  (add_sum),
    .Cout (add_cout)
  );

  assign accept = bus.in_valid && (state_q == ST_ACC);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cflag_d = cflag_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
`ifdef ADD_ACC_SATURATE_EN
          acc_d = add_cout ? 8'hFF : add_sum;
`else
          acc_d = add_sum;
`endif
          cflag_d = cflag_q | add_cout;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
          if (bus.in_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cflag_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cflag_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cflag_q <= cflag_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake flags come from registered state; rst_n gating keeps both low while held in reset.
  assign bus.in_ready  = rst_n && (state_q == ST_ACC);
  assign bus.out_valid = rst_n && (state_q == ST_DONE);
  assign bus.out_sum   = acc_q;
  assign bus.out_cout  = cflag_q;
  assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_add_accumulator_8bit.sv
// Scoreboard bench for add_accumulator_8bit: directed frames plus randomized frames and back-pressure.
module tb_add_accumulator_8bit;
  localparam int COUNT_W = 4;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add_accumulator_8bit_if #(.COUNT_W(COUNT_W)) bus ();

  add_accumulator_8bit #(.COUNT_W(COUNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int sum;
    int cout;
    int count;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   rand_ready  = 1'b0;
  bit   ready_fixed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result computed from the whole frame at once.
  function automatic res_t model(input int words[$]);
    res_t r;
    int   t = 0;
    foreach (words[i]) t += words[i];
    r.count = (words.size() > CNT_MAX) ? CNT_MAX : words.size();
    r.cout  = (t > 255) ? 1 : 0;
`ifdef ADD_ACC_SATURATE_EN
    r.sum   = (t > 255) ? 255 : t;
`else
    r.sum   = t % 256;
`endif
    return r;
  endfunction

  // Single driver of out_ready, updated just after each rising edge.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end
  end

  // Monitor: every output handshake pops one expected result.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got sum %0d with no expected frame", bus.out_sum);
        end else begin
          e = exp_q.pop_front();
          check("out_sum",   32'(bus.out_sum),   32'(e.sum));
          check("out_cout",  32'(bus.out_cout),  32'(e.cout));
          check("out_count", 32'(bus.out_count), 32'(e.count));
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input bit last, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      if (waited >= 200) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: in_ready %b, required 1 within 200 cycles", bus.in_ready);
        break;
      end
      waited++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int words[$], input bit gaps, output int first_wait);
    int w;
    exp_q.push_back(model(words));
    first_wait = 0;
    foreach (words[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_word(8'(words[i]), (i == words.size() - 1), w);
      if (i == 0) first_wait = w;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int w;
    int words[$];
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check("rst_out_cout",  32'(bus.out_cout),  32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    ready_fixed = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic frame, one-cycle out_valid pulse
    send_frame('{8'h0F, 8'h01}, 1'b0, w);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t1_valid_high", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_once", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;

    send_frame('{8'hCC, 8'h33}, 1'b0, w);
    send_frame('{8'hFF, 8'h01}, 1'b0, w);
    bus.in_valid = 1'b0;
    drain();

    // Back-pressure with in_valid asserted during DONE
    ready_fixed = 1'b0;
    @(posedge clk);
    #1;
    send_frame('{8'h05}, 1'b0, w);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_out_sum",   32'(bus.out_sum),   32'h05);
      @(posedge clk);
      #1;
    end
    ready_fixed = 1'b1;
    send_frame('{8'hAA}, 1'b0, w);
    bus.in_valid = 1'b0;
    drain();

    // Count saturation
    words = {};
    for (int i = 0; i < 20; i++) words.push_back(1);
    send_frame(words, 1'b0, w);
    bus.in_valid = 1'b0;
    drain();

    // Reset mid-frame discards the partial frame
    send_word(8'h40, 1'b0, w);
    send_word(8'h40, 1'b0, w);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame('{8'h01}, 1'b0, w);
    bus.in_valid = 1'b0;
    drain();

    // Back-to-back frames with in_valid held high
    send_frame('{8'h10, 8'h20}, 1'b0, w);
    send_frame('{8'h03}, 1'b0, w);
    check("b2b_wait_cycles", 32'(w), 32'd1);
    bus.in_valid = 1'b0;
    drain();

    // Randomized frames with random gaps and random out_ready
    rand_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      words = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) words.push_back(int'($urandom_range(0, 255)));
      send_frame(words, 1'b1, w);
    end
    bus.in_valid = 1'b0;
    drain();
    rand_ready = 1'b0;

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_accumulator_8bit.md
# add_accumulator_8bit

Streaming accumulator that sits directly around `ripple_adder_8bit`. It feeds the adder with each accepted operand and the running total, then consumes `Sum`/`Cout` back into an 8-bit accumulator register. Input words arrive as frames over a valid/ready stream. One result per frame (sum, sticky carry, word count) is presented on a second valid/ready stream for the downstream consumer.

## Interface
- `COUNT_W`, default 4: width of the per-frame word counter.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: `in_data`/`in_last` valid.
- `in_ready` out 1: block accepts a word this cycle.
- `in_data` in 8: operand word.
- `in_last` in 1: final word of frame.
- `out_valid` out 1: frame result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_sum` out 8: accumulated sum.
- `out_cout` out 1: sticky carry; 1 if any add in the frame carried out.
- `out_count` out COUNT_W: number of words in the frame.

## Operation
- One instance of `ripple_adder_8bit`, connected as A=`in_data`, B=`acc`, Cin=0. `acc` is 0 at frame start, so word 1 yields `Sum` = `in_data`.
- State machine has two states:
  - ACC: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- ACC, on accept (`in_valid`&&`in_ready`):
  - `acc` <= `Sum`.
  - `cflag` <= `cflag` | `Cout`.
  - `cnt` <= `cnt`+1, saturating at 2^COUNT_W−1.
  - If `in_last`: go to DONE.
- ACC with no accept: state holds.
- DONE:
  - `out_sum`=`acc`, `out_cout`=`cflag`, `out_count`=`cnt`. All are stable until the handshake.
  - On `out_ready`: clear `acc`, `cflag` and `cnt` to 0, then go to ACC.
  - `in_data`/`in_valid` are ignored.
- Arithmetic is modulo 256; carry is reported only via sticky `out_cout`.
- Count saturation: words beyond 2^COUNT_W−1 are still summed, but `out_count` stays all-ones.
- A single-word frame (`in_last` on the first word) is legal.
- Reset:
  - `rst_n`=0 at any clock edge, including mid-frame or in DONE with a pending result: state=ACC, `acc`=0, `cflag`=0, `cnt`=0. A partial frame or undelivered result is discarded.
  - While `rst_n`=0: `in_ready`=0 and `out_valid`=0.
- Reset values of outputs: `in_ready`=0 (during reset), `out_valid`=0, `out_sum`=0x00, `out_cout`=0, `out_count`=0.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Latency: `out_valid` rises in the cycle after the `in_last` beat is accepted.
- Throughput:
  - 1 word/cycle within a frame.
  - Minimum one DONE cycle per frame.
  - An N-word frame therefore occupies ≥ N+1 cycles.
- The first word of the next frame can be accepted in the cycle after the output handshake.
- Back-pressure: DONE persists indefinitely while `out_ready`=0.
- `out_ready` asserted while in ACC has no effect.

## Configuration
- `ADD_ACC_SATURATE_EN` defined:
  - On any add with `Cout`=1, `acc` <= 0xFF and `cflag` <= 1.
  - Later adds in the frame keep `acc` at 0xFF.
  - `out_sum` is clamped at 0xFF.
- `ADD_ACC_SATURATE_EN` not defined: `acc` wraps modulo 256 and `cflag` is sticky. This is the default build.

## Test plan
- Frame 0x0F, 0x01 (last), `out_ready`=1 → `out_sum`=0x10, `out_cout`=0, `out_count`=2. `out_valid` is high for exactly 1 cycle, in the cycle after the last accept.
- Frame 0xCC, 0x33 (last) → 0xFF, `out_cout`=0, `out_count`=2. Then frame 0xFF, 0x01 (last):
  - Default build → 0x00, `out_cout`=1, `out_count`=2.
  - With `ADD_ACC_SATURATE_EN` → 0xFF, `out_cout`=1.
- Back-pressure: complete frame 0x05 (last), hold `out_ready`=0 for 3 cycles, presenting `in_valid`=1 with 0xAA → `out_valid`=1, `in_ready`=0 and `out_sum`=0x05 all stable for those 3 cycles. After `out_ready`, the next accepted 0xAA starts a new frame with `acc` at 0.
- Count saturation (COUNT_W=4): 20 words of 0x01, last on the 20th → `out_sum`=0x14, `out_count`=15, `out_cout`=0.
- Reset mid-frame:
  - Accept 0x40, 0x40, then `rst_n`=0 for 1 cycle → `in_ready`=0 and `out_valid`=0 during reset.
  - Then frame 0x01 (last) → `out_sum`=0x01, `out_count`=1.
- Back-to-back frames: `in_valid` held continuously, frames {0x10, 0x20 last} and {0x03 last}, `out_ready`=1 → results 0x30/2 then 0x03/1. The 0x03 word is accepted in the cycle after the first output handshake.
